mem_port_arbiter: RTL and testbench

Two-master, in-order memory arbiter that lets the core's instruction-fetch port and data port share one single-port RAM. It sits between the pipeline's `i_*`/`d_*` buses and the memory. It arbitrates request by request, with data priority and an anti-starvation rule for fetch. It tracks outstanding transactions so that in-order memory responses are routed back to the master that issued them.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master in-order arbiter (data priority, fetch anti-starvation) sharing one memory port.
module mem_port_arbiter #(
    parameter int MAX_OUT  = 2,
    parameter int D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);
    localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [MAX_OUT-1:0] owner;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [3:0]         streak;
    logic               sel_d, push, pop, head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    assign sel_d   = d_req && !(i_req && streak == 4'(D_STREAK));
    assign m_req   = (i_req || d_req) && count < CW'(MAX_OUT);
    assign m_addr  = sel_d ? d_addr : i_req ? i_addr : '0;
    assign m_we    = sel_d && d_we;
    assign m_wdata = sel_d ? d_wdata : '0;
    assign m_wstrb = sel_d ? d_wstrb : '0;
    assign d_gnt   = m_req && m_gnt && sel_d;
    assign i_gnt   = m_req && m_gnt && !sel_d;
    assign push    = i_gnt || d_gnt;
    assign pop     = m_rvalid && count != '0;
    assign head    = owner[rd_ptr];
    assign d_rvalid = pop && head;
    assign i_rvalid = pop && !head;
    assign d_rdata  = d_rvalid ? m_rdata : '0;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign busy     = count != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            streak <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                owner[wr_ptr] <= d_gnt;
                wr_ptr        <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            count  <= count + CW'(push) - CW'(pop);
            // streak only counts data wins against a waiting fetch
            streak <= (!i_req || i_gnt) ? 4'd0 :
                      (d_gnt && streak != 4'(D_STREAK)) ? streak + 4'd1 : streak;
            if (m_rvalid && count == '0)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven combinational checks plus directed multi-cycle sequences.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        i_req = 0, d_req = 0, d_we = 0, m_gnt = 0, m_rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [3:0]  d_wstrb = 0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          tests = 0, fails = 0;

    mem_port_arbiter #(.MAX_OUT(2), .D_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, dwe, mg;
        logic [31:0] ia, da, dw;
        logic [3:0]  ds;
        logic        e_req, e_we, e_ig, e_dg;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_st;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_we = 0; m_gnt = 0; m_rvalid = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_n = 0;
        #1 reset_n = 1;
    endtask

    // drive at negedge, settle, then sample well away from posedge
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic exp_d[6];
        logic exp_ig[6];
        vecs[0] = '{0,0,0,1, 32'h100,32'h200,32'hDEAD,4'hF, 0,0,0,0, 32'h0,  32'h0,   4'h0};
        vecs[1] = '{1,0,0,1, 32'h100,32'h200,32'hDEAD,4'hF, 1,0,1,0, 32'h100,32'h0,   4'h0};
        vecs[2] = '{1,0,0,0, 32'h100,32'h200,32'hDEAD,4'hF, 1,0,0,0, 32'h100,32'h0,   4'h0};
        vecs[3] = '{0,1,1,1, 32'h100,32'h200,32'hDEAD,4'hF, 1,1,0,1, 32'h200,32'hDEAD,4'hF};
        vecs[4] = '{1,1,1,1, 32'h100,32'h200,32'hDEAD,4'hF, 1,1,0,1, 32'h200,32'hDEAD,4'hF};
        vecs[5] = '{1,1,0,0, 32'h100,32'h204,32'h55,  4'h0, 1,0,0,0, 32'h204,32'h55,  4'h0};

        #2 chk("reset_busy", busy, 0);
        chk("reset_mreq", m_req, 0);
        chk("reset_err", err, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            i_req = vecs[v].ir; d_req = vecs[v].dr; d_we = vecs[v].dwe; m_gnt = vecs[v].mg;
            i_addr = vecs[v].ia; d_addr = vecs[v].da; d_wdata = vecs[v].dw; d_wstrb = vecs[v].ds;
            #1;
            chk($sformatf("v%0d_m_req", v), m_req, vecs[v].e_req);
            chk($sformatf("v%0d_m_addr", v), m_addr, vecs[v].e_addr);
            chk($sformatf("v%0d_m_we", v), m_we, vecs[v].e_we);
            chk($sformatf("v%0d_m_wdata", v), m_wdata, vecs[v].e_wd);
            chk($sformatf("v%0d_m_wstrb", v), m_wstrb, vecs[v].e_st);
            chk($sformatf("v%0d_i_gnt", v), i_gnt, vecs[v].e_ig);
            chk($sformatf("v%0d_d_gnt", v), d_gnt, vecs[v].e_dg);
        end

        // single fetch
        do_reset();
        i_req = 1; i_addr = 32'h100; m_gnt = 1;
        #1 chk("sf_i_gnt", i_gnt, 1);
        step();
        i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h13;
        #1 chk("sf_busy1", busy, 1);
        chk("sf_i_rvalid", i_rvalid, 1);
        chk("sf_i_rdata", i_rdata, 32'h13);
        chk("sf_d_rvalid", d_rvalid, 0);
        step();
        m_rvalid = 0;
        #1 chk("sf_busy0", busy, 0);

        // contention: D,D,D,D,I,D with streak saturating at 4
        exp_d = '{1,1,1,1,0,1};
        do_reset();
        i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 1; d_wstrb = 4'hF; m_gnt = 1;
        for (int k = 0; k < 6; k++) begin
            d_addr = 32'h400 + 32'(k * 4);
            d_wdata = 32'(k);
            m_rvalid = k > 0;
            #1;
            chk($sformatf("ct%0d_d_gnt", k), d_gnt, exp_d[k]);
            chk($sformatf("ct%0d_i_gnt", k), i_gnt, !exp_d[k]);
            if (k == 2) begin
                chk("ct_count_pp", dut.count, 1);
                chk("ct_wr_ptr", dut.wr_ptr, 0);
                chk("ct_rd_ptr", dut.rd_ptr, 1);
            end
            if (k == 4) begin
                chk("ct_streak4", dut.streak, 4);
                chk("ct_m_addr_i", m_addr, 32'h300);
            end
            if (k == 5) chk("ct_streak0", dut.streak, 0);
            step();
        end

        // outstanding limit with 3-cycle memory latency
        exp_ig = '{1,1,0,0,1,1};
        do_reset();
        i_req = 1; i_addr = 32'h500; m_gnt = 1;
        for (int k = 0; k < 6; k++) begin
            m_rvalid = (k == 3 || k == 4);
            m_rdata = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("ol%0d_i_gnt", k), i_gnt, exp_ig[k]);
            if (k == 3) begin
                chk("ol_full_m_req", m_req, 0);
                chk("ol_i_rvalid3", i_rvalid, 1);
            end
            if (k == 4) chk("ol_i_rvalid4", i_rvalid, 1);
            if (k == 2) chk("ol_i_rvalid2", i_rvalid, 0);
            step();
        end

        // mixed routing: D load, I, D store; responses AA, BB, CC
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h104; m_gnt = 1;
        #1 chk("mx_d_gnt0", d_gnt, 1);
        step();
        d_req = 0;
        #1 chk("mx_i_gnt1", i_gnt, 1);
        step();
        i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h208; d_wdata = 32'h77; d_wstrb = 4'h3;
        m_rvalid = 1; m_rdata = 32'hAA;
        #1 chk("mx_full_m_req", m_req, 0);
        chk("mx_d_rvalid_aa", d_rvalid, 1);
        chk("mx_d_rdata_aa", d_rdata, 32'hAA);
        chk("mx_i_rvalid_aa", i_rvalid, 0);
        step();
        m_rdata = 32'hBB;
        #1 chk("mx_d_gnt3", d_gnt, 1);
        chk("mx_i_rvalid_bb", i_rvalid, 1);
        chk("mx_i_rdata_bb", i_rdata, 32'hBB);
        chk("mx_d_rdata_bb", d_rdata, 0);
        step();
        d_req = 0; d_we = 0; m_rdata = 32'hCC;
        #1 chk("mx_d_rvalid_cc", d_rvalid, 1);
        chk("mx_d_rdata_cc", d_rdata, 32'hCC);
        chk("mx_i_rvalid_cc", i_rvalid, 0);
        step();
        m_rvalid = 0;
        #1 chk("mx_busy0", busy, 0);
        chk("mx_err0", err, 0);

        // asynchronous reset mid-burst, then a stray response
        do_reset();
        i_req = 1; i_addr = 32'h600; m_gnt = 1;
        step();
        step();
        #1 chk("rs_busy_pre", busy, 1);
        chk("rs_count2", dut.count, 2);
        #2 reset_n = 0;
        idle();
        #1 chk("rs_busy_async", busy, 0);
        chk("rs_m_req_async", m_req, 0);
        chk("rs_m_addr_async", m_addr, 0);
        step();
        reset_n = 1;
        step();
        m_rvalid = 1; m_rdata = 32'h99;
        #1 chk("sp_i_rvalid", i_rvalid, 0);
        chk("sp_d_rvalid", d_rvalid, 0);
        chk("sp_err_before", err, 0);
        step();
        m_rvalid = 0;
        #1 chk("sp_err_set", err, 1);
        chk("sp_busy", busy, 0);
        step();
        #1 chk("sp_err_sticky", err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
